// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

  localparam int unsigned DIV_WIDTH = 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Iteration counter width: enough to hold WIDTH-1, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_div_ctrl_div_step.sv
// One restoring-division step: trial subtract and restore mux (combinational).
module div_step
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             qbit
);

  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_diff;

  assign w_trial = {rem, in_bit};
  assign w_diff  = w_trial - {1'b0, divisor};

  // rem < divisor (or the top rem bit is still 0 when divisor is 0), so bit WIDTH of the
  // difference is exactly the borrow.
  assign qbit     = ~w_diff[WIDTH];
  assign next_rem = qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

endmodule

// File: rtl/seq_div_ctrl.sv
// Multi-cycle unsigned restoring divider controller, one quotient bit per cycle, MSB first.
// Optional build macro SEQ_DIV_ZERO_DETECT_EN adds div_by_zero and a fast divide-by-zero path.
module seq_div_ctrl
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef SEQ_DIV_ZERO_DETECT_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_q_sh;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;

  logic [WIDTH-1:0] w_q_sh_n;
  logic [WIDTH-1:0] w_div_n;
  logic [WIDTH-1:0] w_rem_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic             w_busy_n;
  logic             w_done_n;
  logic [WIDTH-1:0] w_quot_n;
  logic [WIDTH-1:0] w_remo_n;

  logic             w_accept;
  logic             w_last;
  logic             w_skip;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_qbit;
  logic [WIDTH-1:0] w_q_shift;

`ifdef SEQ_DIV_ZERO_DETECT_EN
  logic             r_dbz;
  logic             w_dbz_n;
  assign w_skip = (divisor == '0);
`else
  assign w_skip = 1'b0;
`endif

  assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last    = (r_state == S_RUN) && (r_cnt == '0);
  assign w_q_shift = {r_q_sh[WIDTH-2:0], w_qbit};

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (r_rem),
    .in_bit  (r_q_sh[WIDTH-1]),
    .divisor (r_div),
    .next_rem(w_step_rem),
    .qbit    (w_qbit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; DONE without a new request falls back to IDLE.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_next_state = w_skip ? S_DONE : S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == '0) begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output and datapath next values; results only move on the way into DONE.
  always_comb begin
    w_q_sh_n = r_q_sh;
    w_div_n  = r_div;
    w_rem_n  = r_rem;
    w_cnt_n  = r_cnt;
    w_quot_n = r_quot;
    w_remo_n = r_remo;
    w_busy_n = (w_next_state == S_RUN);
    w_done_n = (w_next_state == S_DONE);
`ifdef SEQ_DIV_ZERO_DETECT_EN
    w_dbz_n  = r_dbz;
`endif
    if (w_accept) begin
      w_q_sh_n = dividend;
      w_div_n  = divisor;
      w_rem_n  = '0;
      w_cnt_n  = CNT_LAST;
`ifdef SEQ_DIV_ZERO_DETECT_EN
      w_dbz_n  = w_skip;
      if (w_skip) begin
        w_quot_n = '1;
        w_remo_n = dividend;
      end
`endif
    end else if (r_state == S_RUN) begin
      w_q_sh_n = w_q_shift;
      w_rem_n  = w_step_rem;
      if (w_last) begin
        w_quot_n = w_q_shift;
        w_remo_n = w_step_rem;
      end else begin
        w_cnt_n = r_cnt - CNT_W'(1);
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_sh <= '0;
      r_div  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_quot <= '0;
      r_remo <= '0;
    end else begin
      r_q_sh <= w_q_sh_n;
      r_div  <= w_div_n;
      r_rem  <= w_rem_n;
      r_cnt  <= w_cnt_n;
      r_busy <= w_busy_n;
      r_done <= w_done_n;
      r_quot <= w_quot_n;
      r_remo <= w_remo_n;
    end
  end

`ifdef SEQ_DIV_ZERO_DETECT_EN
  // Divide-by-zero flag, held until the next accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dbz <= 1'b0;
    end else begin
      r_dbz <= w_dbz_n;
    end
  end

  assign div_by_zero = r_dbz;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_remo;

endmodule

// File: tb/tb_seq_div_ctrl.sv
// Self-checking bench for seq_div_ctrl: vector table, random operands vs. arithmetic model,
// and hand-written sequences for ignored start, mid-run reset and back-to-back requests.
module tb_seq_div_ctrl;

  localparam int WIDTH = 9;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
`ifdef SEQ_DIV_ZERO_DETECT_EN
  logic             div_by_zero;
`endif

  int checks = 0;
  int errors = 0;

  seq_div_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder)
`ifdef SEQ_DIV_ZERO_DETECT_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned q;
    int unsigned r;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Edges after the accept edge until done is seen (edge k -> cycle k+1).
  function automatic int unsigned exp_edges(input int unsigned b);
`ifdef SEQ_DIV_ZERO_DETECT_EN
    if (b == 0) return 0;
`endif
    return WIDTH;
  endfunction

  function automatic int unsigned model_q(input int unsigned a, input int unsigned b);
    return (b == 0) ? MAXV : a / b;
  endfunction

  function automatic int unsigned model_r(input int unsigned a, input int unsigned b);
    return (b == 0) ? a : a % b;
  endfunction

  // Issue one request and check latency, busy span, result hold and results.
  // poke > 0 re-pulses start with other operands on that edge index while busy.
  task automatic run_div(input string nm, input int unsigned a, input int unsigned b,
                         input int unsigned eq, input int unsigned er, input int poke);
    int unsigned hq, hr, nb;
    int lat;
    bit bad_hold;
    @(negedge clk);
    dividend = WIDTH'(a);
    divisor  = WIDTH'(b);
    start    = 1'b1;
    hq = quotient;
    hr = remainder;
    lat = -1;
    nb = 0;
    bad_hold = 1'b0;
    @(posedge clk);
    for (int k = 0; k <= 2 * WIDTH + 4; k++) begin
      #1;
      if (poke > 0 && k == poke) begin
        start    = 1'b1;
        dividend = WIDTH'(5);
        divisor  = WIDTH'(5);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = k;
        break;
      end
      if (busy) nb++;
      if (quotient != WIDTH'(hq) || remainder != WIDTH'(hr)) bad_hold = 1'b1;
      @(posedge clk);
    end
    start = 1'b0;
    check({nm, " latency"}, lat, exp_edges(b));
    check({nm, " busy_cycles"}, nb, exp_edges(b));
    check({nm, " hold"}, 32'(bad_hold), 0);
    check({nm, " quotient"}, quotient, eq);
    check({nm, " remainder"}, remainder, er);
`ifdef SEQ_DIV_ZERO_DETECT_EN
    check({nm, " div_by_zero"}, 32'(div_by_zero), (b == 0) ? 1 : 0);
`endif
  endtask

  initial begin
    int d1, d2;
    bit saw_done;
    int unsigned ra, rb;

    vecs[0] = '{a: 23,  b: 9,   q: 2,   r: 5};
    vecs[1] = '{a: 511, b: 1,   q: 511, r: 0};
    vecs[2] = '{a: 0,   b: 7,   q: 0,   r: 0};
    vecs[3] = '{a: 500, b: 0,   q: 511, r: 500};
    vecs[4] = '{a: 511, b: 511, q: 1,   r: 0};
    vecs[5] = '{a: 1,   b: 511, q: 0,   r: 1};
    vecs[6] = '{a: 256, b: 2,   q: 128, r: 0};
    vecs[7] = '{a: 510, b: 255, q: 2,   r: 0};

    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 0);
    end

    // Start during RUN with different operands must be ignored.
    run_div("ignore_start", 100, 7, 14, 2, 4);

    // Reset mid-run: outputs clear at once and done never pulses.
    @(negedge clk);
    dividend = WIDTH'(100);
    divisor  = WIDTH'(3);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 0);
    check("midrst done", 32'(done), 0);
    check("midrst quotient", quotient, 0);
    check("midrst remainder", remainder, 0);
    saw_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("midrst no_done", 32'(saw_done), 0);
    run_div("after_rst", 300, 17, 17, 11, 0);

    // Back-to-back: start held high through DONE.
    @(negedge clk);
    dividend = WIDTH'(400);
    divisor  = WIDTH'(20);
    start    = 1'b1;
    d1 = -1;
    d2 = -1;
    @(posedge clk);
    for (int k = 0; k < 60; k++) begin
      #1;
      if (k == 0) begin
        dividend = WIDTH'(255);
        divisor  = WIDTH'(16);
      end
      if (done && d1 < 0) begin
        d1 = k;
        check("b2b first quotient", quotient, 20);
        check("b2b first remainder", remainder, 0);
      end else if (done && d1 >= 0) begin
        d2 = k;
        break;
      end
      if (d1 >= 0 && k > d1) start = 1'b0;
      @(posedge clk);
    end
    start = 1'b0;
    check("b2b first done", d1, exp_edges(20));
    check("b2b second done", d2, exp_edges(20) + exp_edges(16) + 1);
    check("b2b second quotient", quotient, 15);
    check("b2b second remainder", remainder, 15);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom_range(0, MAXV);
      if (i % 8 == 0) rb = 0;
      else if (i % 3 == 0) rb = $urandom_range(1, 15);
      else rb = $urandom_range(1, MAXV);
      run_div($sformatf("rand%0d_%0d_%0d", i, ra, rb), ra, rb, model_q(ra, rb), model_r(ra, rb), 0);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
